combo_lock_param: RTL and testbench
===================================

Name: combo_lock_param

Overview:
- Parametrised N-digit combination lock for the DE0-Nano style board designs.
- Fixes the progress-leak weakness: the lock evaluates the whole sequence only after all digits are entered, and exposes no per-digit match information.
- Adds debounced entry, failure counting with a timed lockout, auto-relock after a timed open, and an entry timeout.
- Runs entirely on one clock with clock enables; there are no derived clocks.

Parameters:
- DIGIT_W, 4, width of one combination digit (switch bank width).
- NUM_DIGITS, 4, digits per combination (>=1).
- COMBO, 16'h8421, DIGIT_W*NUM_DIGITS bits; first digit in MS slice.
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (>=1).
- LOCKOUT_CYCLES, 250000000, lockout duration in clock cycles.
- OPEN_CYCLES, 500000000, open duration before auto-relock; 0 = stay open until LOCK_REQ.
- ENTRY_TIMEOUT, 500000000, idle cycles after which a partial entry is discarded; 0 = disabled.
- DEBOUNCE_CYCLES, 500000, cycles the enter button must be stable before its level is accepted (>=1).

Ports:
- CLOCK_50, in, 1, system clock.
- RESET_N, in, 1, asynchronous active-low reset.
- DIGIT, in, DIGIT_W, digit switches; async, sampled through 2-FF sync.
- ENTER_N, in, 1, enter push button, active-low, async, bouncy.
- LOCK_REQ, in, 1, synchronous single-cycle request to relock while open.
- OPEN, out, 1, lock open.
- LOCKED_OUT, out, 1, lockout in progress.
- DIGITS_ENTERED, out, $clog2(NUM_DIGITS+1), digits accepted in current attempt.
- FAIL_COUNT, out, $clog2(MAX_FAILS+1), consecutive failures.
- ENTER_ACK, out, 1, one-cycle pulse per accepted digit.

Behaviour:
- Reset (async assert, sync deassert via internal 2-FF reset sync):
  - State ENTRY; all counters 0; mismatch flag 0.
  - OPEN=0, LOCKED_OUT=0, DIGITS_ENTERED=0, FAIL_COUNT=0, ENTER_ACK=0.
- Input path:
  - ENTER_N and DIGIT each pass through a 2-FF synchroniser.
  - Debounce counter restarts on any change of the synced ENTER_N. The stable level updates only after DEBOUNCE_CYCLES unchanged cycles.
  - A 1->0 transition of the stable level produces press, a single cycle.
  - Release produces nothing; holding the button yields exactly one press.
- ENTRY:
  - On press, compare synced DIGIT with COMBO slice [(NUM_DIGITS-1-idx)*DIGIT_W +: DIGIT_W]. A mismatch sets the sticky mismatch flag.
  - idx increments, ENTER_ACK=1 the following cycle, and DIGITS_ENTERED=idx.
  - A wrong digit never aborts the attempt early; all NUM_DIGITS digits are always collected.
  - On press when idx==NUM_DIGITS-1, go to CHECK.
- CHECK (1 cycle):
  - Mismatch flag clear -> OPEN state; FAIL_COUNT=0.
  - Otherwise FAIL_COUNT+1; if that equals MAX_FAILS -> LOCKOUT, else back to ENTRY.
  - In both cases idx=0 and mismatch=0.
  - FAIL_COUNT saturates at MAX_FAILS.
- OPEN:
  - OPEN=1 while in this state; presses are ignored.
  - Leave to ENTRY on LOCK_REQ, or after OPEN_CYCLES cycles if OPEN_CYCLES!=0.
  - LOCK_REQ takes priority if both occur in the same cycle.
  - LOCK_REQ outside OPEN is ignored.
- LOCKOUT:
  - LOCKED_OUT=1; presses are ignored, with no ENTER_ACK.
  - After LOCKOUT_CYCLES cycles -> ENTRY with FAIL_COUNT=0.
- Entry timeout:
  - Applies in ENTRY with idx>0.
  - A counter clears on every press. At ENTRY_TIMEOUT cycles it discards the attempt: idx=0, mismatch=0.
  - A timeout is not counted as a failure.
  - If the timeout and a press occur in the same cycle, the press wins.
- Latency:
  - DIGITS_ENTERED and ENTER_ACK update 1 cycle after press.
  - OPEN asserts 2 cycles after the final press (via CHECK).
- The OPEN/fail outcome is visible only after the full digit count, so no per-digit leak exists.
- Unused state encodings -> ENTRY.
- Timer widths are sized by $clog2 of their respective parameter.

Test Plan:
Sim parameters: DIGIT_W=4, NUM_DIGITS=4, COMBO=16'h8421, MAX_FAILS=3, LOCKOUT_CYCLES=100, OPEN_CYCLES=50, ENTRY_TIMEOUT=200, DEBOUNCE_CYCLES=4.
- Correct entry:
  - Stimulus: enter 8,4,2,1, each press held 10 cycles.
  - Response: 4 ENTER_ACK pulses, DIGITS_ENTERED 1..4 then 0; OPEN=1 for exactly 50 cycles, then 0; FAIL_COUNT=0.
- No leak:
  - Stimulus: enter 3,4,2,1.
  - Response: all 4 digits are acked and OPEN stays 0. After digit 4, FAIL_COUNT=1; no output differs from the correct case before the 4th press.
- Lockout:
  - Stimulus: three wrong attempts, then 8,4,2,1 during lockout.
  - Response: LOCKED_OUT=1 for 100 cycles, presses are unacked, FAIL_COUNT=3. Afterwards FAIL_COUNT=0, and a correct entry opens the lock.
- Bounce and timeout:
  - Stimulus: ENTER_N toggling every 2 cycles for 20 cycles, then held low.
  - Response: exactly 1 ENTER_ACK.
  - Stimulus: 2 digits, then idle 200 cycles.
  - Response: DIGITS_ENTERED returns to 0 and FAIL_COUNT is unchanged.
- Relock and reset:
  - Stimulus: LOCK_REQ while open.
  - Response: OPEN drops the next cycle.
  - Stimulus: RESET_N low mid-entry (idx=2), then release.
  - Response: all outputs are 0 immediately (async), and a fresh 4-digit correct entry opens.

Source files
------------

// File: rtl/combo_lock_param.sv
// N-digit combination lock: debounced entry, whole-sequence check, fail-count lockout,
// timed auto-relock and partial-entry timeout, all on one clock with enables.
module combo_lock_param #(
  parameter int unsigned                      DIGIT_W         = 4,
  parameter int unsigned                      NUM_DIGITS      = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0]    COMBO           = 16'h8421,
  parameter int unsigned                      MAX_FAILS       = 3,
  parameter int unsigned                      LOCKOUT_CYCLES  = 250000000,
  parameter int unsigned                      OPEN_CYCLES     = 500000000,
  parameter int unsigned                      ENTRY_TIMEOUT   = 500000000,
  parameter int unsigned                      DEBOUNCE_CYCLES = 500000
) (
  input  logic                                CLOCK_50,
  input  logic                                RESET_N,
  input  logic [DIGIT_W-1:0]                  DIGIT,
  input  logic                                ENTER_N,
  input  logic                                LOCK_REQ,
  output logic                                OPEN,
  output logic                                LOCKED_OUT,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     DIGITS_ENTERED,
  output logic [$clog2(MAX_FAILS+1)-1:0]      FAIL_COUNT,
  output logic                                ENTER_ACK
);

  localparam int unsigned IdxW  = $clog2(NUM_DIGITS + 1);
  localparam int unsigned FailW = $clog2(MAX_FAILS + 1);
  localparam int unsigned DbW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned LockW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam int unsigned OpenW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam int unsigned ToW   = (ENTRY_TIMEOUT > 1) ? $clog2(ENTRY_TIMEOUT) : 1;

  localparam logic [DbW-1:0]   DbMax   = DbW'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 32'd0);
  localparam logic [LockW-1:0] LockMax = LockW'((LOCKOUT_CYCLES > 0) ? LOCKOUT_CYCLES - 1 : 32'd0);
  localparam logic [OpenW-1:0] OpenMax = OpenW'((OPEN_CYCLES > 0) ? OPEN_CYCLES - 1 : 32'd0);
  localparam logic [ToW-1:0]   ToMax   = ToW'((ENTRY_TIMEOUT > 0) ? ENTRY_TIMEOUT - 1 : 32'd0);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NUM_DIGITS - 1);
  localparam logic [FailW-1:0] FailMax = FailW'(MAX_FAILS);

  typedef enum logic [1:0] {StEntry, StCheck, StOpen, StLockout} state_e;

  logic [1:0]         r_rst_sync;
  logic               w_rst_n;
  logic [1:0]         r_enter_s;
  logic [DIGIT_W-1:0] r_digit_s1, r_digit_s2;
  logic               r_db_last, r_stable, r_stable_dly;
  logic [DbW-1:0]     r_db_cnt;
  logic               w_press;
  logic [DIGIT_W-1:0] w_exp_digit;

  state_e             r_state;
  logic [IdxW-1:0]    r_idx;
  logic               r_mismatch;
  logic [FailW-1:0]   r_fails;
  logic               r_open, r_locked, r_ack;
  logic [OpenW-1:0]   r_open_cnt;
  logic [LockW-1:0]   r_lock_cnt;
  logic [ToW-1:0]     r_to_cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Stable level only follows the synced button after DEBOUNCE_CYCLES unchanged cycles.
  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_enter_s    <= 2'b11;
      r_digit_s1   <= '0;
      r_digit_s2   <= '0;
      r_db_last    <= 1'b1;
      r_db_cnt     <= '0;
      r_stable     <= 1'b1;
      r_stable_dly <= 1'b1;
    end else begin
      r_enter_s    <= {r_enter_s[0], ENTER_N};
      r_digit_s1   <= DIGIT;
      r_digit_s2   <= r_digit_s1;
      r_stable_dly <= r_stable;
      if (r_enter_s[1] != r_db_last) begin
        r_db_last <= r_enter_s[1];
        r_db_cnt  <= '0;
      end else if (r_db_cnt == DbMax) begin
        r_stable <= r_db_last;
      end else begin
        r_db_cnt <= r_db_cnt + DbW'(1);
      end
    end
  end

  assign w_press = r_stable_dly & ~r_stable;

  always_comb begin
    w_exp_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IdxW'(i)) w_exp_digit = COMBO[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
    end
  end

  always_ff @(posedge CLOCK_50 or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state    <= StEntry;
      r_idx      <= '0;
      r_mismatch <= 1'b0;
      r_fails    <= '0;
      r_open     <= 1'b0;
      r_locked   <= 1'b0;
      r_ack      <= 1'b0;
      r_open_cnt <= '0;
      r_lock_cnt <= '0;
      r_to_cnt   <= '0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        StEntry: begin
          // A press beats a simultaneous timeout; wrong digits never end the attempt early.
          if (w_press) begin
            r_ack    <= 1'b1;
            r_idx    <= r_idx + IdxW'(1);
            r_to_cnt <= '0;
            if (r_digit_s2 != w_exp_digit) r_mismatch <= 1'b1;
            if (r_idx == LastIdx) r_state <= StCheck;
          end else if ((ENTRY_TIMEOUT != 0) && (r_idx != '0)) begin
            if (r_to_cnt == ToMax) begin
              r_idx      <= '0;
              r_mismatch <= 1'b0;
              r_to_cnt   <= '0;
            end else begin
              r_to_cnt <= r_to_cnt + ToW'(1);
            end
          end else begin
            r_to_cnt <= '0;
          end
        end
        StCheck: begin
          r_idx      <= '0;
          r_mismatch <= 1'b0;
          r_to_cnt   <= '0;
          if (!r_mismatch) begin
            r_state    <= StOpen;
            r_open     <= 1'b1;
            r_fails    <= '0;
            r_open_cnt <= '0;
          end else begin
            if (r_fails != FailMax) r_fails <= r_fails + FailW'(1);
            if (r_fails >= FailMax - FailW'(1)) begin
              r_state    <= StLockout;
              r_locked   <= 1'b1;
              r_lock_cnt <= '0;
            end else begin
              r_state <= StEntry;
            end
          end
        end
        StOpen: begin
          if (LOCK_REQ || ((OPEN_CYCLES != 0) && (r_open_cnt == OpenMax))) begin
            r_state <= StEntry;
            r_open  <= 1'b0;
          end else if (OPEN_CYCLES != 0) begin
            r_open_cnt <= r_open_cnt + OpenW'(1);
          end
        end
        StLockout: begin
          if (r_lock_cnt == LockMax) begin
            r_state  <= StEntry;
            r_locked <= 1'b0;
            r_fails  <= '0;
          end else begin
            r_lock_cnt <= r_lock_cnt + LockW'(1);
          end
        end
        default: begin
          r_state    <= StEntry;
          r_idx      <= '0;
          r_mismatch <= 1'b0;
          r_open     <= 1'b0;
          r_locked   <= 1'b0;
        end
      endcase
    end
  end

  assign OPEN           = r_open;
  assign LOCKED_OUT     = r_locked;
  assign DIGITS_ENTERED = r_idx;
  assign FAIL_COUNT     = r_fails;
  assign ENTER_ACK      = r_ack;

endmodule

// File: tb/tb_combo_lock_param.sv
// Directed and randomized bench for combo_lock_param with an attempt-level reference model.
module tb_combo_lock_param;

  localparam int unsigned MF = 3;
  localparam int unsigned LC = 100;
  localparam int unsigned OC = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enter_n = 1'b1;
  logic       lock_req = 1'b0;
  logic [3:0] digit = 4'd0;
  logic       open_o, locked_o, ack_o;
  logic [2:0] digits_o;
  logic [1:0] fails_o;

  int n_tests = 0;
  int n_fail = 0;
  int ack_total = 0;
  int open_total = 0;
  int lock_total = 0;
  int d4_total = 0;

  // Reference model state: the combination as a digit list and the consecutive-fail count.
  int ref_combo[4] = '{8, 4, 2, 1};
  int ref_fails = 0;
  bit ref_locked = 1'b0;

  combo_lock_param #(
    .DIGIT_W(4), .NUM_DIGITS(4), .COMBO(16'h8421), .MAX_FAILS(MF),
    .LOCKOUT_CYCLES(LC), .OPEN_CYCLES(OC), .ENTRY_TIMEOUT(200), .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk), .RESET_N(rst_n), .DIGIT(digit), .ENTER_N(enter_n), .LOCK_REQ(lock_req),
    .OPEN(open_o), .LOCKED_OUT(locked_o), .DIGITS_ENTERED(digits_o), .FAIL_COUNT(fails_o),
    .ENTER_ACK(ack_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ack_o) ack_total <= ack_total + 1;
    if (open_o) open_total <= open_total + 1;
    if (locked_o) lock_total <= lock_total + 1;
    if (digits_o == 3'd4) d4_total <= d4_total + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    enter_n = 1'b0;
    tick(10);
    enter_n = 1'b1;
    tick(10);
  endtask

  task automatic wait_low(input string tag, input bit which_open, input int budget);
    int n = 0;
    while ((which_open ? open_o : locked_o) && (n < budget)) begin
      tick(1);
      n++;
    end
    chk({tag, " drop"}, 32'(which_open ? open_o : locked_o), 32'd0);
  endtask

  // One 4-digit attempt; when not ignored, the outcome is predicted from the model.
  task automatic attempt(input string tag, input int d0, d1, d2, d3, input bit ignored);
    int ds[4];
    int a0, q0;
    bit good;
    ds = '{d0, d1, d2, d3};
    q0 = d4_total;
    for (int k = 0; k < 4; k++) begin
      a0 = ack_total;
      press(4'(ds[k]));
      chk($sformatf("%s ack%0d", tag, k), 32'(ack_total - a0), ignored ? 32'd0 : 32'd1);
      if (k < 3) begin
        chk($sformatf("%s digits%0d", tag, k), 32'(digits_o), ignored ? 32'd0 : 32'(k + 1));
        chk($sformatf("%s open%0d", tag, k), 32'(open_o), 32'd0);
        chk($sformatf("%s fails%0d", tag, k), 32'(fails_o), 32'(ref_fails));
      end
    end
    if (!ignored) begin
      good = 1'b1;
      for (int k = 0; k < 4; k++) if (ds[k] != ref_combo[k]) good = 1'b0;
      if (good) ref_fails = 0;
      else if (ref_fails < MF) ref_fails++;
      if (ref_fails == MF) ref_locked = 1'b1;
      chk({tag, " saw4"}, 32'(d4_total - q0), 32'd1);
      chk({tag, " digits end"}, 32'(digits_o), 32'd0);
      chk({tag, " open"}, 32'(open_o), 32'(good));
      chk({tag, " fails"}, 32'(fails_o), 32'(ref_fails));
      chk({tag, " locked"}, 32'(locked_o), 32'(ref_locked));
    end
  endtask

  initial begin
    int o0, l0, a0;
    int rd[4];
    bit use_good;

    #1 rst_n = 1'b0;
    tick(3);
    chk("rst open", 32'(open_o), 32'd0);
    chk("rst locked", 32'(locked_o), 32'd0);
    chk("rst digits", 32'(digits_o), 32'd0);
    chk("rst fails", 32'(fails_o), 32'd0);
    chk("rst ack", 32'(ack_o), 32'd0);
    rst_n = 1'b1;
    tick(4);

    o0 = open_total;
    attempt("correct", 8, 4, 2, 1, 1'b0);
    tick(60);
    chk("open width", 32'(open_total - o0), 32'(OC));
    chk("open relocked", 32'(open_o), 32'd0);

    o0 = open_total;
    attempt("noleak", 3, 4, 2, 1, 1'b0);
    tick(20);
    chk("noleak never open", 32'(open_total - o0), 32'd0);

    l0 = lock_total;
    attempt("wrong2", 1, 1, 1, 1, 1'b0);
    attempt("wrong3", 8, 4, 2, 0, 1'b0);
    attempt("during lockout", 8, 4, 2, 1, 1'b1);
    chk("lockout fails", 32'(fails_o), 32'(MF));
    wait_low("lockout", 1'b0, 60);
    ref_locked = 1'b0;
    ref_fails = 0;
    chk("lockout width", 32'(lock_total - l0), 32'(LC));
    chk("lockout fails clr", 32'(fails_o), 32'd0);
    attempt("after lockout", 8, 4, 2, 1, 1'b0);
    wait_low("open after lockout", 1'b1, 60);

    a0 = ack_total;
    digit = 4'd8;
    for (int i = 0; i < 10; i++) begin
      enter_n = ~enter_n;
      tick(2);
    end
    enter_n = 1'b0;
    tick(10);
    enter_n = 1'b1;
    tick(10);
    chk("bounce acks", 32'(ack_total - a0), 32'd1);
    chk("bounce digits", 32'(digits_o), 32'd1);
    press(4'd4);
    chk("timeout pre", 32'(digits_o), 32'd2);
    tick(150);
    chk("timeout not early", 32'(digits_o), 32'd2);
    tick(60);
    chk("timeout digits", 32'(digits_o), 32'd0);
    chk("timeout fails", 32'(fails_o), 32'd0);

    attempt("relock", 8, 4, 2, 1, 1'b0);
    lock_req = 1'b1;
    tick(1);
    lock_req = 1'b0;
    chk("lock_req drops open", 32'(open_o), 32'd0);
    press(4'd8);
    lock_req = 1'b1;
    tick(1);
    lock_req = 1'b0;
    chk("lock_req ignored", 32'(digits_o), 32'd1);

    press(4'd4);
    chk("mid entry", 32'(digits_o), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async open", 32'(open_o), 32'd0);
    chk("async locked", 32'(locked_o), 32'd0);
    chk("async digits", 32'(digits_o), 32'd0);
    chk("async fails", 32'(fails_o), 32'd0);
    chk("async ack", 32'(ack_o), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    ref_fails = 0;
    ref_locked = 1'b0;
    attempt("post reset", 8, 4, 2, 1, 1'b0);
    wait_low("post reset open", 1'b1, 60);

    for (int t = 0; t < 12; t++) begin
      use_good = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) rd[k] = use_good ? ref_combo[k] : int'($urandom_range(0, 15));
      attempt($sformatf("rand%0d", t), rd[0], rd[1], rd[2], rd[3], 1'b0);
      if (ref_locked) begin
        wait_low($sformatf("rand%0d lock", t), 1'b0, 120);
        ref_locked = 1'b0;
        ref_fails = 0;
        chk($sformatf("rand%0d fails clr", t), 32'(fails_o), 32'd0);
      end
      wait_low($sformatf("rand%0d open", t), 1'b1, 70);
      tick(int'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
